u_dec: RTL and testbench
========================

U_DEC -- requirements
Module: u_dec

Interface
REQ-001 SHALL have parameter W, default 32: input vector width, minimum 2.
REQ-002 SHALL have parameter P_ADMIT_COMPLIMENT_EN, default 1: when 1, complemented unary codes are admitted.
REQ-003 SHALL have parameter P_ERR_CNT_W, default 16: width of the error counter.
REQ-004 SHALL define derived constant CW = $clog2(W+1) as the count width.
REQ-005 SHALL have port i_clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-006 SHALL have port i_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port i_vld, input, 1 bit: input word valid.
REQ-008 SHALL have port i_x, input, W bits: candidate thermometer-coded word.
REQ-009 SHALL have port o_rdy, output, 1 bit: block can accept an input word.
REQ-010 SHALL have port o_vld, output, 1 bit: decoded result valid.
REQ-011 SHALL have port i_rdy, input, 1 bit: downstream accepts the result.
REQ-012 SHALL have port o_cnt, output, CW bits: decoded binary count.
REQ-013 SHALL have port o_cmpl, output, 1 bit: word was the complemented form.
REQ-014 SHALL have port o_err, output, 1 bit: word was not admitted.
REQ-015 SHALL have port i_err_clr, input, 1 bit: clear the error counter.
REQ-016 SHALL have port o_err_cnt, output, P_ERR_CNT_W bits: saturating count of rejected words.

Function
REQ-017 SHALL define standard unary as ones contiguous from bit 0 with zeros above, e.g. 0..0111, where the count is the number of ones.
REQ-018 SHALL define complemented unary as zeros contiguous from bit 0 with ones above, e.g. 1..1000, where the count is the number of zeros; it is admitted only when P_ADMIT_COMPLIMENT_EN=1.
REQ-019 SHALL decode all-zeros as standard: cnt=0, cmpl=0.
REQ-020 SHALL decode all-ones as standard: cnt=W, cmpl=0; o_cmpl is never 1 for these two words.
REQ-021 SHALL, for a rejected word, output o_err=1, o_cnt=0 and o_cmpl=0.
REQ-022 SHALL transfer a word on an input handshake whenever i_vld && o_rdy are both high in a cycle.
REQ-023 SHALL transfer a result on an output handshake whenever o_vld && i_rdy are both high in a cycle.
REQ-024 SHALL implement a two-stage pipeline: stage S1 registers i_x and performs the admission check; stage S2 registers cnt, cmpl and err.
REQ-025 SHALL present a result on the output a fixed 2 cycles after its input handshake when there is no backpressure.
REQ-026 SHALL sustain one word per cycle when i_rdy stays high.
REQ-027 SHALL drive o_rdy = !S1.vld || S2 can advance, where S2 can advance = !o_vld || i_rdy; o_rdy has no combinational path from i_vld.
REQ-028 SHALL hold o_vld, o_cnt, o_cmpl and o_err stable while o_vld && !i_rdy.
REQ-029 SHALL never drop or duplicate a word; results leave in input order.
REQ-030 SHALL increment o_err_cnt once per rejected word, at the cycle that word moves from S1 to S2, and saturate at all-ones.
REQ-031 SHALL give i_err_clr priority over a coincident increment, so the counter reads 0 on the next cycle.

Reset
REQ-032 SHALL, while i_rst_n=0 at a clock edge, clear S1.vld and S2.vld.
REQ-033 SHALL reset outputs to o_vld=0, o_cnt=0, o_cmpl=0, o_err=0 and o_err_cnt=0.
REQ-034 SHALL drive o_rdy=1 in the first cycle after reset is deasserted.
REQ-035 SHALL, on reset asserted mid-stream, discard in-flight words without emitting them; the data registers need no reset.

Structure
REQ-036 SHALL place the CW derivation function and the result struct {err, cmpl, cnt} in shared package u_pkg.
REQ-037 SHALL instantiate the existing admission checker u as its one sub-module in S1, passing W and P_ADMIT_COMPLIMENT_EN through.
REQ-038 SHALL generate the count from S1 using a priority, leading-one or leading-zero style encoder, not a separate unary-validity test.

Verification
REQ-039 SHALL cover W=8, EN=1, no stall: 0x07, 0xF8, 0x00, 0xFF, 0x5A sent back-to-back -> outputs on cycles 2..6 are {3,0,0}, {3,1,0}, {0,0,0}, {8,0,0}, {0,0,1}; err_cnt=1.
REQ-040 SHALL cover W=8, EN=0: input 0xF8 -> err=1, cnt=0; err_cnt increments.
REQ-041 SHALL cover backpressure: 4 words sent, i_rdy=0 for 5 cycles -> o_rdy falls after 2 accepted words, outputs are held stable, and all 4 arrive in order once i_rdy=1.
REQ-042 SHALL cover saturation: P_ERR_CNT_W=2 with 5 invalid words -> err_cnt=3; then i_err_clr together with an invalid word -> err_cnt=0.
REQ-043 SHALL cover reset mid-stream: 2 words in flight, then i_rst_n=0 for 1 cycle -> o_vld=0 and nothing emitted; next cycle o_rdy=1.
REQ-044 SHALL cover exhaustive random: all 256 W=8 words under random i_vld/i_rdy -> every result matches the reference model, with no loss or reorder.

Source files
------------

// File: rtl/u_pkg.sv
// Shared definitions for the thermometer/unary decoder: count-width helper
// and the per-word decode result carried through the pipeline.
package u_pkg;

  // Widest count the result struct can carry (W up to 65535).
  localparam int U_CNT_MAX_W = 16;

  function automatic int cw_f(input int w);
    return $clog2(w + 1);
  endfunction

  typedef struct packed {
    logic                   err;
    logic                   cmpl;
    logic [U_CNT_MAX_W-1:0] cnt;
  } u_res_t;

endpackage

// File: rtl/u_dec_u.sv
// Admission checker: flags a word as standard unary (ones from bit 0) or,
// when enabled, complemented unary (zeros from bit 0, ones above).
module u
  import u_pkg::*;
#(
  parameter int W                     = 32,
  parameter bit P_ADMIT_COMPLIMENT_EN = 1'b1
) (
  input  logic [W-1:0] x,
  output logic         ok,
  output logic         cmpl
);

  logic [W-2:0] rise;
  logic [W-2:0] fall;
  logic         is_std;
  logic         is_cmp;

  // A 0 below a 1 breaks standard form; a 1 below a 0 breaks complemented form.
  genvar gi;
  generate
    for (gi = 0; gi < W - 1; gi++) begin : g_edge
      assign rise[gi] = !x[gi] && x[gi+1];
      assign fall[gi] = x[gi] && !x[gi+1];
    end
  endgenerate

  assign is_std = ~|rise;
  assign is_cmp = ~|fall;

  // All-zeros and all-ones satisfy both shapes and are reported as standard.
  assign cmpl = P_ADMIT_COMPLIMENT_EN && is_cmp && !is_std;
  assign ok   = is_std || cmpl;

endmodule

// File: rtl/u_dec.sv
// Two-stage valid/ready unary decoder: S1 holds the word and admits it,
// S2 holds {err, cmpl, cnt}; rejected words bump a saturating error counter.
module u_dec
  import u_pkg::*;
#(
  parameter int  W                     = 32,
  parameter bit  P_ADMIT_COMPLIMENT_EN = 1'b1,
  parameter int  P_ERR_CNT_W           = 16,
  localparam int CW                    = cw_f(W)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_vld,
  input  logic [W-1:0]           i_x,
  output logic                   o_rdy,
  output logic                   o_vld,
  input  logic                   i_rdy,
  output logic [CW-1:0]          o_cnt,
  output logic                   o_cmpl,
  output logic                   o_err,
  input  logic                   i_err_clr,
  output logic [P_ERR_CNT_W-1:0] o_err_cnt
);

  logic                   s1_vld_reg;
  logic [W-1:0]           s1_x_reg;
  logic                   s2_vld_reg;
  u_res_t                 s2_res_reg;
  logic [P_ERR_CNT_W-1:0] err_cnt_reg;

  logic                   s2_adv;
  logic                   s1_rdy;
  logic                   adm_ok;
  logic                   adm_cmpl;
  logic [CW-1:0]          lo_cnt;
  logic [CW-1:0]          tz_cnt;
  logic [CW-1:0]          cnt_sel;
  u_res_t                 s1_res_next;
  logic                   err_inc;

  assign s2_adv = !s2_vld_reg || i_rdy;
  assign s1_rdy = !s1_vld_reg || s2_adv;

  u #(
    .W                    (W),
    .P_ADMIT_COMPLIMENT_EN(P_ADMIT_COMPLIMENT_EN)
  ) u_adm (
    .x   (s1_x_reg),
    .ok  (adm_ok),
    .cmpl(adm_cmpl)
  );

  // Leading-one position + 1 gives the standard count; the lowest one's
  // index is the zero run length of a complemented word.
  always_comb begin
    lo_cnt = '0;
    for (int i = 0; i < W; i++) begin
      if (s1_x_reg[i]) lo_cnt = CW'(i + 1);
    end
    tz_cnt = CW'(W);
    for (int i = W - 1; i >= 0; i--) begin
      if (s1_x_reg[i]) tz_cnt = CW'(i);
    end
  end

  always_comb begin
    cnt_sel          = adm_cmpl ? tz_cnt : lo_cnt;
    s1_res_next      = '0;
    s1_res_next.err  = !adm_ok;
    s1_res_next.cmpl = adm_ok && adm_cmpl;
    s1_res_next.cnt  = adm_ok ? U_CNT_MAX_W'(cnt_sel) : '0;
  end

  assign err_inc = s2_adv && s1_vld_reg && s1_res_next.err && !(&err_cnt_reg);

  // Data register only loads on a handshake; in-flight words are dropped by
  // clearing the valids, so it needs no reset.
  always_ff @(posedge i_clk) begin
    if (s1_rdy && i_vld) begin
      s1_x_reg <= i_x;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_vld_reg  <= 1'b0;
      s2_vld_reg  <= 1'b0;
      s2_res_reg  <= '0;
      err_cnt_reg <= '0;
    end else begin
      if (s1_rdy) begin
        s1_vld_reg <= i_vld;
      end
      if (s2_adv) begin
        s2_vld_reg <= s1_vld_reg;
        if (s1_vld_reg) begin
          s2_res_reg <= s1_res_next;
        end
      end
      if (i_err_clr) begin
        err_cnt_reg <= '0;
      end else if (err_inc) begin
        err_cnt_reg <= err_cnt_reg + P_ERR_CNT_W'(1);
      end
    end
  end

  assign o_rdy     = s1_rdy;
  assign o_vld     = s2_vld_reg;
  assign o_cnt     = s2_res_reg.cnt[CW-1:0];
  assign o_cmpl    = s2_res_reg.cmpl;
  assign o_err     = s2_res_reg.err;
  assign o_err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_u_dec.sv
// Directed + random bench for u_dec (W=8) with a scoreboard queue; a second
// instance with complemented admission disabled covers the EN=0 behaviour.
module tb_u_dec;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_vld;
  logic [7:0] i_x;
  logic       o_rdy;
  logic       o_vld;
  logic       i_rdy;
  logic [3:0] o_cnt;
  logic       o_cmpl;
  logic       o_err;
  logic       i_err_clr;
  logic [1:0] o_err_cnt;

  logic        n_vld;
  logic [7:0]  n_x;
  logic        n_ordy;
  logic        n_ovld;
  logic [3:0]  n_cnt;
  logic        n_cmpl;
  logic        n_err;
  logic [15:0] n_err_cnt;

  always #5 i_clk = ~i_clk;

  u_dec #(.W(8), .P_ADMIT_COMPLIMENT_EN(1'b1), .P_ERR_CNT_W(2)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_vld    (i_vld),
    .i_x      (i_x),
    .o_rdy    (o_rdy),
    .o_vld    (o_vld),
    .i_rdy    (i_rdy),
    .o_cnt    (o_cnt),
    .o_cmpl   (o_cmpl),
    .o_err    (o_err),
    .i_err_clr(i_err_clr),
    .o_err_cnt(o_err_cnt)
  );

  u_dec #(.W(8), .P_ADMIT_COMPLIMENT_EN(1'b0), .P_ERR_CNT_W(16)) dut_n (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_vld    (n_vld),
    .i_x      (n_x),
    .o_rdy    (n_ordy),
    .o_vld    (n_ovld),
    .i_rdy    (1'b1),
    .o_cnt    (n_cnt),
    .o_cmpl   (n_cmpl),
    .o_err    (n_err),
    .i_err_clr(1'b0),
    .o_err_cnt(n_err_cnt)
  );

  typedef struct {
    logic [7:0] x;
    logic [5:0] res;   // {err, cmpl, cnt}
    int         due;
  } exp_t;

  exp_t sb[$];
  int   n_asrt   = 0;
  int   n_fail   = 0;
  int   cyc_n    = 0;
  int   err_seen = 0;
  bit   chk_lat  = 1'b0;

  // Reference: match the word against every legal unary pattern.
  function automatic logic [5:0] ref_dec(input logic [7:0] v, input bit en);
    logic [8:0] m;
    logic [7:0] m2;
    for (int n = 0; n <= 8; n++) begin
      m = (9'd1 << n) - 9'd1;
      if ({1'b0, v} == m) return {2'b00, 4'(n)};
    end
    if (en) begin
      for (int n = 1; n < 8; n++) begin
        m2 = 8'hFF << n;
        if (v == m2) return {2'b01, 4'(n)};
      end
    end
    return 6'b100000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs just after a negedge, score both handshakes, move on.
  task automatic cyc(input logic v, input logic [7:0] xv, input logic r, output bit acc);
    exp_t e;
    i_vld = v;
    i_x   = xv;
    i_rdy = r;
    #1;
    acc = v && o_rdy;
    if (o_vld) begin
      if (sb.size() == 0) begin
        chk("spurious_out", 32'(o_vld), 32'(0));
      end else begin
        e = sb[0];
        if (r) begin
          chk("out_data", 32'({o_err, o_cmpl, o_cnt}), 32'(e.res));
          if (chk_lat) chk("latency", cyc_n, e.due);
          $display("out x=0x%02h err=%0b cmpl=%0b cnt=%0d", e.x, o_err, o_cmpl, o_cnt);
          void'(sb.pop_front());
        end else begin
          chk("hold_data", 32'({o_err, o_cmpl, o_cnt}), 32'(e.res));
        end
      end
    end
    if (acc) begin
      e.x   = xv;
      e.res = ref_dec(xv, 1'b1);
      e.due = cyc_n + 2;
      sb.push_back(e);
      if (e.res[5]) err_seen++;
    end
    @(negedge i_clk);
    cyc_n++;
  endtask

  task automatic send(input logic [7:0] xv);
    bit acc = 1'b0;
    for (int k = 0; k < 50 && !acc; k++) cyc(1'b1, xv, 1'b1, acc);
    chk("send_accept", 32'(acc), 32'(1));
  endtask

  task automatic drain();
    bit acc;
    for (int k = 0; k < 30 && sb.size() > 0; k++) cyc(1'b0, 8'h00, 1'b1, acc);
    chk("drain_empty", sb.size(), 0);
    chk("drain_idle_vld", 32'(o_vld), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         acc;
    bit         v;
    bit         r;
    int         n_acc;
    logic [7:0] seq [5];

    i_rst_n = 1'b0; i_vld = 1'b0; i_x = '0; i_rdy = 1'b0; i_err_clr = 1'b0;
    n_vld = 1'b0; n_x = '0;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    chk("rst_o_vld", 32'(o_vld), 32'(0));
    chk("rst_o_res", 32'({o_err, o_cmpl, o_cnt}), 32'(0));
    chk("rst_err_cnt", 32'(o_err_cnt), 32'(0));
    chk("rst_o_rdy", 32'(o_rdy), 32'(1));
    @(negedge i_clk);

    // Back-to-back, no stall, fixed two-cycle latency.
    chk_lat = 1'b1;
    seq[0] = 8'h07; seq[1] = 8'hF8; seq[2] = 8'h00; seq[3] = 8'hFF; seq[4] = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, seq[i], 1'b1, acc);
      chk("b2b_accept", 32'(acc), 32'(1));
    end
    drain();
    chk("err_cnt_b2b", 32'(o_err_cnt), 32'(1));
    chk_lat = 1'b0;

    // Complement admission disabled: 0xF8 rejected, all-ones still standard.
    n_vld = 1'b1; n_x = 8'hF8;
    @(negedge i_clk);
    n_x = 8'hFF;
    @(negedge i_clk);
    n_vld = 1'b0;
    #1;
    chk("en0_f8_vld", 32'(n_ovld), 32'(1));
    chk("en0_f8_res", 32'({n_err, n_cmpl, n_cnt}), 32'(6'b100000));
    @(negedge i_clk);
    #1;
    chk("en0_ff_res", 32'({n_ovld, n_err, n_cmpl, n_cnt}), 32'(7'b1_00_1000));
    chk("en0_err_cnt", 32'(n_err_cnt), 32'(1));
    @(negedge i_clk);

    // Backpressure: two words fill the pipe, then o_rdy must stay low.
    cyc(1'b1, 8'h01, 1'b0, acc);
    chk("bp_acc0", 32'(acc), 32'(1));
    cyc(1'b1, 8'h3F, 1'b0, acc);
    chk("bp_acc1", 32'(acc), 32'(1));
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 8'hE0, 1'b0, acc);
      chk("bp_rdy_low", 32'(acc), 32'(0));
    end
    send(8'hE0);
    send(8'h22);
    drain();

    // Reset with two words in flight: nothing may come out afterwards.
    send(8'h07);
    send(8'h03);
    i_rst_n = 1'b0; i_vld = 1'b0; i_rdy = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    sb.delete();
    err_seen = 0;
    #1;
    chk("midrst_o_vld", 32'(o_vld), 32'(0));
    chk("midrst_o_rdy", 32'(o_rdy), 32'(1));
    chk("midrst_err_cnt", 32'(o_err_cnt), 32'(0));
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, acc);
    chk("midrst_no_emit", 32'(o_vld), 32'(0));

    // Saturation of the 2-bit counter, then clear coinciding with an increment.
    for (int i = 0; i < 5; i++) send(8'h5A);
    drain();
    chk("sat_err_cnt", 32'(o_err_cnt), 32'(3));
    send(8'h81);
    i_err_clr = 1'b1;
    cyc(1'b0, 8'h00, 1'b1, acc);
    i_err_clr = 1'b0;
    #1;
    chk("clr_priority", 32'(o_err_cnt), 32'(0));
    err_seen = 0;
    drain();
    chk("clr_hold", 32'(o_err_cnt), 32'(0));

    // Every 8-bit word under random valid/ready.
    n_acc = 0;
    for (int i = 0; i < 256; i++) begin
      acc = 1'b0;
      for (int k = 0; k < 100 && !acc; k++) begin
        v = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 2) != 0);
        cyc(v, 8'(i), r, acc);
      end
      if (acc) n_acc++;
    end
    chk("rand_accepted", n_acc, 256);
    drain();
    chk("rand_err_cnt", 32'(o_err_cnt), 32'((err_seen > 3) ? 3 : err_seen));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
